// File: rtl/alu_dst_writeback.sv
// alu_dst_writeback: routes ALU results to a buffered register-file write,
// a negated register-file write, the flag register, or discard.
// Register writes drain in order through a small FIFO. Flag updates bypass it.
module alu_dst_writeback #(
  parameter int DW     = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     alu_result,
  input  logic [1:0]        Sel_Dst,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DW-1:0]     rf_wr_data,
  input  logic              rf_wr_ready,
  output logic [DW-1:0]     fl_out,
  output logic              wb_pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    DST_REG     = 2'b00,
    DST_REG_NEG = 2'b01,
    DST_FLAG    = 2'b10,
    DST_DISCARD = 2'b11
  } dst_sel_e;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DW-1:0]     data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [DW-1:0]     fl;

  dst_sel_e          sel;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fl_wr;
  logic [DW-1:0]     push_data;

  // Handshake and routing decode; in_ready depends only on registered count.
  always_comb begin
    sel       = dst_sel_e'(Sel_Dst);
    in_ready  = (count < CW'(DEPTH));
    accept    = in_valid & in_ready;
    push      = accept & ((sel == DST_REG) | (sel == DST_REG_NEG));
    fl_wr     = accept & (sel == DST_FLAG);
    pop       = (count != '0) & rf_wr_ready;
    push_data = (sel == DST_REG_NEG) ? (~alu_result + DW'(1)) : alu_result;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= dst_addr;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flag register updates at acceptance, independent of pending writes.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      fl <= '0;
    end else if (fl_wr) begin
      fl <= alu_result;
    end
  end

  // Outputs are selected purely from registered state.
  always_comb begin
    rf_wr_en   = (count != '0);
    wb_pending = (count != '0);
    rf_wr_addr = addr_mem[rd_ptr];
    rf_wr_data = data_mem[rd_ptr];
    fl_out     = fl;
  end

endmodule

// File: tb/tb_alu_dst_writeback.sv
// Directed testbench for alu_dst_writeback with hand-computed expectations.
module tb_alu_dst_writeback;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] alu_result = '0;
  logic [1:0] Sel_Dst = 2'b00;
  logic [3:0] dst_addr = '0;
  logic       rf_wr_en;
  logic [3:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_ready = 1'b0;
  logic [7:0] fl_out;
  logic       wb_pending;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  alu_dst_writeback #(.DW(8), .ADDR_W(4), .DEPTH(2)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_result  (alu_result),
    .Sel_Dst     (Sel_Dst),
    .dst_addr    (dst_addr),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_wr_ready (rf_wr_ready),
    .fl_out      (fl_out),
    .wb_pending  (wb_pending)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [1:0] sel, input logic [7:0] res, input logic [3:0] addr);
    in_valid   = 1'b1;
    Sel_Dst    = sel;
    alu_result = res;
    dst_addr   = addr;
  endtask

  task automatic check_head(input string tag, input logic [3:0] addr, input logic [7:0] data);
    check({tag, "_en"}, rf_wr_en, 1);
    check({tag, "_addr"}, rf_wr_addr, addr);
    check({tag, "_data"}, rf_wr_data, data);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_en", rf_wr_en, 0);
    check("rst_addr", rf_wr_addr, 0);
    check("rst_data", rf_wr_data, 0);
    check("rst_fl", fl_out, 0);
    check("rst_pend", wb_pending, 0);
    check("rst_rdy", in_ready, 1);

    // 1: reset mid-operation drops buffered writes and flag
    rf_wr_ready = 1'b0;
    offer(2'b10, 8'h77, 4'd0); tick();
    offer(2'b00, 8'h11, 4'd1); tick();
    offer(2'b00, 8'h22, 4'd2); tick();
    in_valid = 1'b0;
    check("t1_fl_pre", fl_out, 8'h77);
    check("t1_full_rdy", in_ready, 0);
    check_head("t1_head", 4'd1, 8'h11);
    #2 reset = 1'b1;
    #1;
    check("t1_en", rf_wr_en, 0);
    check("t1_rdy", in_ready, 1);
    check("t1_fl", fl_out, 0);
    check("t1_pend", wb_pending, 0);
    reset = 1'b0;
    tick();

    // 2: single plain write, one cycle latency, one cycle on the port
    rf_wr_ready = 1'b1;
    offer(2'b00, 8'h3C, 4'd5); tick();
    in_valid = 1'b0;
    check_head("t2_head", 4'd5, 8'h3C);
    tick();
    check("t2_en_off", rf_wr_en, 0);
    check("t2_pend", wb_pending, 0);
    tick();
    check("t2_empty_pop_rdy", in_ready, 1);
    check("t2_empty_pop_pend", wb_pending, 0);

    // 3: negated writes streaming with simultaneous push/pop
    offer(2'b01, 8'h05, 4'd7); tick();
    check_head("t3_a", 4'd7, 8'hFB);
    offer(2'b01, 8'h80, 4'd8); tick();
    check_head("t3_b", 4'd8, 8'h80);
    offer(2'b01, 8'h00, 4'd9); tick();
    check_head("t3_c", 4'd9, 8'h00);
    in_valid = 1'b0;
    tick();
    check("t3_drained", wb_pending, 0);

    // 4: flag write, then discard
    offer(2'b10, 8'hA5, 4'd3); tick();
    in_valid = 1'b0;
    check("t4_fl", fl_out, 8'hA5);
    check("t4_en", rf_wr_en, 0);
    offer(2'b11, 8'hFF, 4'd4); tick();
    in_valid = 1'b0;
    check("t4_fl_hold", fl_out, 8'hA5);
    check("t4_en2", rf_wr_en, 0);
    check("t4_pend", wb_pending, 0);

    // 5: backpressure fills FIFO, third offer held, then drain in order
    rf_wr_ready = 1'b0;
    offer(2'b00, 8'h0A, 4'd1); tick();
    offer(2'b00, 8'h0B, 4'd2); tick();
    offer(2'b00, 8'h0C, 4'd3);
    check("t5_full_rdy", in_ready, 0);
    tick();
    check("t5_held_rdy", in_ready, 0);
    check_head("t5_stable", 4'd1, 8'h0A);
    rf_wr_ready = 1'b1;
    tick();
    check_head("t5_b", 4'd2, 8'h0B);
    check("t5_rdy_free", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_head("t5_c", 4'd3, 8'h0C);
    tick();
    check("t5_done_pend", wb_pending, 0);
    check("t5_done_rdy", in_ready, 1);

    // 6a: count=1, push and pop together
    rf_wr_ready = 1'b0;
    offer(2'b00, 8'h61, 4'd4); tick();
    offer(2'b00, 8'h62, 4'd6);
    rf_wr_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_head("t6_b", 4'd6, 8'h62);
    check("t6_rdy", in_ready, 1);
    tick();
    check("t6_empty", wb_pending, 0);

    // 6b: full FIFO refuses flag update, even in a popping cycle
    rf_wr_ready = 1'b0;
    offer(2'b00, 8'h71, 4'd1); tick();
    offer(2'b00, 8'h72, 4'd2); tick();
    offer(2'b10, 8'h5A, 4'd0);
    check("t6_full_rdy", in_ready, 0);
    tick();
    check("t6_fl_refused", fl_out, 8'hA5);
    rf_wr_ready = 1'b1;
    tick();
    check("t6_fl_no_pass", fl_out, 8'hA5);
    check_head("t6_after_pop", 4'd2, 8'h72);
    tick();
    in_valid = 1'b0;
    check("t6_fl_taken", fl_out, 8'h5A);
    check("t6_final_pend", wb_pending, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
